// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripherals: register offsets, STATUS bit
// positions and the transmitter FSM encoding.
package uart_pkg;

  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;

  localparam int ST_BUSY   = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;
  localparam int ST_CNT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored; a simultaneous push and pop leaves the count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Bus-mapped 8N1 UART transmitter: register window, TX FIFO, baud counter and
// frame FSM. The FSM state is kept in `state` for hierarchical observation.
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx,
  output logic        irq_empty
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);

  uart_state_t   state;
  logic [15:0]   baud_div;
  logic [15:0]   bit_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic          ovf;
  logic          tx_q;
  logic [31:0]   status;

  logic          wr_txdata, wr_status, wr_baud;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div_m1;
  logic          bit_end;
  logic          busy;
  logic          unused_bits;

  assign wr_txdata = sel && WE && (A[3:2] == UART_TXDATA[3:2]);
  assign wr_status = sel && WE && (A[3:2] == UART_STATUS[3:2]);
  assign wr_baud   = sel && WE && (A[3:2] == UART_BAUDDIV[3:2]);

  // A divisor of 0 behaves like 1: the counter reloads with 0 every bit.
  assign div_m1   = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign bit_end  = (bit_cnt == 16'd0);
  assign fifo_pop = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign irq_empty = fifo_empty && (state == S_IDLE);
  assign tx        = tx_q;

  assign unused_bits = ^{A[1:0], WD[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .wdata (WD[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status = '0;
    status[ST_BUSY]                = busy;
    status[ST_FULL]                = fifo_full;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_OVF]                 = ovf;
    status[ST_CNT_LO +: ST_CNT_W]  = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    RD = '0;
    if (sel) begin
      case (A[3:2])
        UART_STATUS[3:2]:  RD = status;
        UART_BAUDDIV[3:2]: RD = {16'd0, baud_div};
        default:           RD = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_div <= DIV_RST;
      ovf      <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= WD[15:0];
      if (wr_txdata && fifo_full) ovf <= 1'b1;
      else if (wr_status && WD[ST_OVF]) ovf <= 1'b0;
    end
  end

  // tx is registered: each transition drives the level of the state it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift   <= fifo_head;
            bit_idx <= '0;
            bit_cnt <= div_m1;
            tx_q    <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= div_m1;
            tx_q    <= shift[0];
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= div_m1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              shift   <= fifo_head;
              bit_idx <= '0;
              bit_cnt <= div_m1;
              tx_q    <= 1'b0;
              state   <= S_START;
            end else begin
              tx_q  <= 1'b1;
              state <= S_IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: bus driver tasks, a line monitor that decodes
// frames from tx and checks them against an expected-byte queue.
module tb_uart_tx_periph;

  localparam logic [3:0] ADR_TX   = 4'h0;
  localparam logic [3:0] ADR_ST   = 4'h4;
  localparam logic [3:0] ADR_BAUD = 4'h8;
  localparam logic [3:0] ADR_RSV  = 4'hC;
  localparam int         DEF_DIV  = 868;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic [3:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        tx;
  logic        irq_empty;

  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          cyc;
  int          cur_div;
  int          total;
  int          passed;

  uart_tx_periph dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RD        (RD),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // driver tasks
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; WE = 1'b1; A = a; WD = d;
    @(negedge clk);
    sel = 1'b0; WE = 1'b0; WD = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; WE = 1'b0; A = a;
    #1;
    d = RD;
    sel = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int bound, output int t);
    for (int i = 0; i < bound; i++) begin
      if (irq_empty) break;
      @(negedge clk);
    end
    t = cyc;
    check(name, {31'd0, irq_empty}, 32'd1);
  endtask

  // monitor: decodes each frame at bit centres and pops the scoreboard
  initial begin : monitor
    int         t0;
    int         d;
    logic       aborted;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (rst_n && (tx == 1'b0)) begin
        t0 = cyc;
        d = cur_div;
        start_q.push_back(t0);
        aborted = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
          if (!aborted) begin
            while ((cyc < t0 + k * d + d / 2) && rst_n) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            else bits[k] = tx;
          end
        end
        if (!aborted) begin
          while ((cyc < t0 + 10 * d - 1) && rst_n) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {22'd0, bits}, 32'hFFFF_FFFF);
          end else begin
            check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
            check("frame_start_stop", {30'd0, bits[9], bits[0]}, 32'd2);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] r;
    logic [7:0]  b;
    int          w, s, t, n, hi;
    total = 0; passed = 0;
    cur_div = DEF_DIV;
    rst_n = 1'b0; sel = 1'b0; WE = 1'b0; A = '0; WD = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq_empty}, 32'd1);
    bus_read(ADR_ST, r);   check("rst_status", r, 32'h4);
    bus_read(ADR_BAUD, r); check("rst_bauddiv", r, DEF_DIV);

    // single frame 0xA5, BAUDDIV=4
    cur_div = 4;
    bus_write(ADR_BAUD, 32'd4);
    start_q.delete();
    exp_q.push_back(8'hA5);
    bus_write(ADR_TX, 32'hA5);
    w = cyc;
    check("t1_tx_before_pop", {31'd0, tx}, 32'd1);
    check("t1_irq_fall", {31'd0, irq_empty}, 32'd0);
    bus_read(ADR_ST, r); check("t1_status_cnt1", r, 32'h11);
    @(negedge clk);
    check("t1_tx_low", {31'd0, tx}, 32'd0);
    wait_idle("t1_idle_timeout", 200, t);
    check("t1_irq_rise", t - w, 32'd41);
    check("t1_start_lat", (start_q.size() > 0) ? start_q[0] - w : -1, 32'd1);

    // burst of three, BAUDDIV=2
    cur_div = 2;
    bus_write(ADR_BAUD, 32'd2);
    start_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    bus_write(ADR_TX, 32'h01);
    w = cyc;
    bus_write(ADR_TX, 32'h02);
    bus_write(ADR_TX, 32'h03);
    s = w + 1;
    wait_until(s + 10); bus_read(ADR_ST, r); check("t2_cnt2", (r >> 4) & 32'h1F, 32'd2);
    wait_until(s + 30); bus_read(ADR_ST, r); check("t2_cnt1", (r >> 4) & 32'h1F, 32'd1);
    wait_until(s + 50); bus_read(ADR_ST, r); check("t2_cnt0", (r >> 4) & 32'h1F, 32'd0);
    wait_idle("t2_idle_timeout", 200, t);
    check("t2_end", t - s, 32'd60);
    check("t2_frames", start_q.size(), 32'd3);
    check("t2_gap01", (start_q.size() >= 3) ? start_q[1] - start_q[0] : -1, 32'd20);
    check("t2_gap12", (start_q.size() >= 3) ? start_q[2] - start_q[1] : -1, 32'd20);

    // overflow: one byte in the shifter, then nine more
    cur_div = 4;
    bus_write(ADR_BAUD, 32'd4);
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(ADR_TX, {24'd0, b});
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) exp_q.push_back(b);
      bus_write(ADR_TX, {24'd0, b});
    end
    bus_read(ADR_ST, r); check("t3_full_ovf", r, 32'h8B);
    bus_write(ADR_ST, 32'h8);
    bus_read(ADR_ST, r); check("t3_ovf_clear", r, 32'h83);
    wait_idle("t3_idle_timeout", 1000, t);
    check("t3_drained", exp_q.size(), 32'd0);
    bus_read(ADR_ST, r); check("t3_status_end", r, 32'h4);

    // randomized bursts against the expected-byte queue
    for (int round = 0; round < 4; round++) begin
      n = $urandom_range(0, 5);
      cur_div = (n == 0) ? 1 : n;
      bus_write(ADR_BAUD, n);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        bus_write(ADR_TX, {24'd0, b});
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rnd_idle_timeout", 600, t);
      check("rnd_drained", exp_q.size(), 32'd0);
      bus_read(ADR_ST, r); check("rnd_status", r, 32'h4);
    end

    // reset pulse during data bit 3
    cur_div = 4;
    bus_write(ADR_BAUD, 32'd4);
    bus_write(ADR_TX, 32'h3C);
    w = cyc;
    wait_until(w + 1 + 17);
    rst_n = 1'b0;
    #1;
    check("t4_tx_async", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    cur_div = DEF_DIV;
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(ADR_ST, r);   check("t4_status", r, 32'h4);
    bus_read(ADR_BAUD, r); check("t4_bauddiv", r, DEF_DIV);
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx) hi++;
    end
    check("t4_tx_quiet", hi, 32'd100);

    // BAUDDIV=0 acts as 1, plus read-decode corners
    cur_div = 1;
    bus_write(ADR_BAUD, 32'd0);
    exp_q.push_back(8'hFF);
    bus_write(ADR_TX, 32'hFF);
    w = cyc;
    wait_idle("t5_idle_timeout", 100, t);
    check("t5_frame_len", t - w, 32'd11);
    bus_read(ADR_RSV, r); check("t5_rsv_read", r, 32'd0);
    bus_write(ADR_RSV, 32'hFFFF_FFFF);
    bus_read(ADR_BAUD, r); check("t5_rsv_write_ignored", r, 32'd0);
    bus_read(ADR_TX, r); check("t5_txdata_read", r, 32'd0);
    sel = 1'b0; A = ADR_ST; #1;
    check("t5_nosel_status", RD, 32'd0);
    A = ADR_BAUD; #1;
    check("t5_nosel_baud", RD, 32'd0);

    repeat (5) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
